booth_mac_accumulator: RTL
==========================

# booth_mac_accumulator

Downstream consumer of the sequential Booth multiplier. It accepts a stream of signed 2N-bit products over a valid/ready handshake and sums a programmed number of them into a wider saturating accumulator. It presents the final sum on a held output handshake, forming the accumulate half of a multiply-accumulate / dot-product datapath.

## Interface
- N, 10: multiplier operand width; products are 2N bits signed
- ACC_W, 2N+8: accumulator/result width, signed; must be ≥ 2N
- CNT_W, 8: width of the product-count field
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- start  in  1  one-cycle request to begin a new accumulation; honoured only in IDLE
- len  in  CNT_W  number of products to accumulate; sampled with start
- p_valid  in  1  product available from multiplier
- p_data  in  2N  signed product
- p_ready  out  1  block accepts p_data this cycle
- out_valid  out  1  result available
- out_data  out  ACC_W  signed accumulated result
- out_ready  in  1  consumer takes result
- overflow  out  1  saturation occurred during current/last accumulation
- busy  out  1  high in ACC and DONE

## Operation
- FSM states: IDLE, ACC, DONE.
- IDLE: p_ready=0, out_valid=0, busy=0.
  - start & len≠0: acc←0, remaining←len, overflow←0, go ACC.
  - start & len=0: acc←0, overflow←0, go DONE directly.
- ACC: p_ready=1, busy=1.
  - On p_valid&p_ready: acc←sat(acc + sign-extend(p_data)), remaining←remaining−1.
  - Handshake with remaining=1: go DONE.
  - p_valid low: no change; no timeout.
- DONE: out_valid=1, out_data=acc, busy=1, p_ready=0.
  - out_ready high: go IDLE. out_data stays stable while waiting.
- Arithmetic: sum computed at ACC_W+1 bits.
  - Above 2^(ACC_W−1)−1: clamp to max and set overflow.
  - Below −2^(ACC_W−1): clamp to min and set overflow.
  - overflow is sticky until the next accepted start.
  - Accumulation continues from the clamped value.
- start outside IDLE is ignored; len is not re-sampled.
- p_data is ignored whenever p_ready=0.

## Timing
- Reset (async assert, synchronous-release use): state=IDLE, acc=0, remaining=0.
  - Outputs: p_ready=0, out_valid=0, out_data=0, overflow=0, busy=0.
- Reset mid-operation aborts immediately; no partial result is emitted.
- start sampled at edge k: p_ready=1 from cycle k+1.
- Throughput: one product per cycle when p_valid is held high.
- Last product accepted at edge j: out_valid=1 in cycle j+1.
- Minimum start→out_valid latency: len+1 cycles; len=0 gives 1 cycle.
- Result handshake at edge m: out_valid=0 and IDLE in cycle m+1.
  - A new start is accepted at edge m+1 at the earliest.
  - A start coincident with the result handshake (edge m) is ignored.
- out_data updates only on accepted products and on start. It is registered with no combinational path from p_data.
- p_ready depends only on state; there is no combinational path from p_valid or out_ready.

## Test plan
- Reset: assert rst_n=0 mid-ACC after 2 of 5 products -> all outputs at reset values within the same cycle; next start with len=1, product 9 -> out_data=9.
- Basic sum, N=10: start len=3, products 100, −250, 7 back-to-back -> out_valid exactly 4 cycles after start, out_data=−143, overflow=0.
- Saturation, N=4, ACC_W=9: len=5, products 64 ×5 -> out_data=255, overflow=1. Then len=5, products −64 ×5 -> out_data=−256, overflow=1. Then len=1, product 3 -> out_data=3, overflow=0.
- Handshake stalls: len=4, p_valid toggling 1,0,0,1,1,0,1; out_ready held low 3 cycles -> only valid beats counted; out_data stable and out_valid high throughout the stall; IDLE one cycle after out_ready.
- Boundary: start with len=0 -> out_valid next cycle, out_data=0. start pulsed during ACC with a different len -> ignored; original count completes.
- Max count: len=255, product 1 each cycle -> out_data=255 at cycle 256 after start; p_ready drops immediately after the 255th beat.

Source files
------------

// File: rtl/booth_mac_accumulator.sv
// Saturating accumulator for the signed products of the sequential Booth multiplier.
// It sums a programmed number of products, then holds the sum on a result handshake.
module booth_mac_accumulator #(
    parameter int N     = 10,
    parameter int ACC_W = 2*N + 8,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [CNT_W-1:0]   len,
    input  logic               p_valid,
    input  logic [2*N-1:0]     p_data,
    output logic               p_ready,
    output logic               out_valid,
    output logic [ACC_W-1:0]   out_data,
    input  logic               out_ready,
    output logic               overflow,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               ovf_q, ovf_d;

    logic [ACC_W:0]     sum_ext;
    logic               sum_hi, sum_lo;
    logic [ACC_W-1:0]   sum_sat;

    // One guard bit: the two top bits disagree exactly when the true sum leaves ACC_W range.
    assign sum_ext = {acc_q[ACC_W-1], acc_q}
                   + {{(ACC_W+1-2*N){p_data[2*N-1]}}, p_data};
    assign sum_hi  = ~sum_ext[ACC_W] &  sum_ext[ACC_W-1];
    assign sum_lo  =  sum_ext[ACC_W] & ~sum_ext[ACC_W-1];

    always_comb begin
        sum_sat = sum_ext[ACC_W-1:0];
        if (sum_hi) begin
            sum_sat = ACC_MAX;
        end else if (sum_lo) begin
            sum_sat = ACC_MIN;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len == '0) ? DONE : ACC;
                end
            end
            ACC: begin
                if (p_valid) begin
                    acc_d = sum_sat;
                    rem_d = rem_q - CNT_W'(1);
                    if (sum_hi || sum_lo) begin
                        ovf_d = 1'b1;
                    end
                    if (rem_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    // Handshake outputs come straight from state so nothing upstream feeds back combinationally.
    assign p_ready   = (state_q == ACC);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = acc_q;
    assign overflow  = ovf_q;

endmodule
